// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, opcode map, bubble encoding and the
// fetch-stage state type used by the fetch unit and its IF/ID register.
package cpu_pkg;

   // Default datapath widths for the fetch stage
   localparam int CPU_PC_WIDTH    = 8;
   localparam int CPU_INSTR_WIDTH = 9;
   localparam int CPU_CNT_WIDTH   = 16;

   // 5-bit opcode field lives in instr[8:4]
   localparam logic [4:0] OP_ADD    = 5'b00000;
   localparam logic [4:0] OP_SUB    = 5'b00001;
   localparam logic [4:0] OP_AND    = 5'b00010;
   localparam logic [4:0] OP_OR     = 5'b00011;
   localparam logic [4:0] OP_XOR    = 5'b00100;
   localparam logic [4:0] OP_SHL    = 5'b00101;
   localparam logic [4:0] OP_SHR    = 5'b00110;
   localparam logic [4:0] OP_ADDI   = 5'b01000;
   localparam logic [4:0] OP_LOADI  = 5'b01001;
   localparam logic [4:0] OP_LOAD   = 5'b10000;
   localparam logic [4:0] OP_STORE  = 5'b10001;
   localparam logic [4:0] OP_BEQ    = 5'b11000;
   localparam logic [4:0] OP_JMP    = 5'b11001;
   localparam logic [4:0] OP_HALT   = 5'b11010;
   localparam logic [4:0] OP_BUBBLE = 5'b11011;

   // Word placed in IF/ID when there is no real instruction; decodes to
   // an opcode with no architectural effect
   localparam logic [8:0] BUBBLE_WORD = {OP_BUBBLE, 4'b0000};

   // Fetch-stage control state
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction word, its PC and a valid bit.
// Control priority is flush (load BUBBLE, clear valid, keep pc) over
// load (capture the fetched word) over hold.
module if_id_reg
   import cpu_pkg::*;
#(
   parameter int                     PC_WIDTH    = CPU_PC_WIDTH,
   parameter int                     INSTR_WIDTH = CPU_INSTR_WIDTH,
   parameter logic [INSTR_WIDTH-1:0] BUBBLE      = BUBBLE_WORD
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_load,
   input  logic                   i_flush,
   input  logic [INSTR_WIDTH-1:0] i_instr,
   input  logic [PC_WIDTH-1:0]    i_pc,
   output logic [INSTR_WIDTH-1:0] o_instr,
   output logic [PC_WIDTH-1:0]    o_pc,
   output logic                   o_valid
);

   logic [INSTR_WIDTH-1:0] r_instr;
   logic [PC_WIDTH-1:0]    r_pc;
   logic                   r_valid;

   // Pipeline register update: flush beats load, otherwise hold
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_instr <= BUBBLE;
         r_pc    <= '0;
         r_valid <= 1'b0;
      end else if (i_flush) begin
         r_instr <= BUBBLE;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_instr <= i_instr;
         r_pc    <= i_pc;
         r_valid <= 1'b1;
      end
   end

   assign o_instr = r_instr;
   assign o_pc    = r_pc;
   assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, drives the ROM address, and feeds
// the IF/ID register. Handles start/restart, branch redirect (which also
// cancels a speculative halt), stall, halt detection and a saturating
// count of delivered instructions.
//
// Control priority in every state: start, branch_taken, stall, fetch.
// In IDLE only start is honoured. In HALTED stall is irrelevant: after the
// halt word has been visible for one cycle IF/ID carries bubbles.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                     PC_WIDTH    = CPU_PC_WIDTH,
   parameter int                     INSTR_WIDTH = CPU_INSTR_WIDTH,
   parameter logic [4:0]             HALT_OP     = OP_HALT,
   parameter logic [INSTR_WIDTH-1:0] BUBBLE      = BUBBLE_WORD,
   parameter int                     CNT_WIDTH   = CPU_CNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [PC_WIDTH-1:0]    start_addr,
   input  logic                   stall,
   input  logic                   branch_taken,
   input  logic [PC_WIDTH-1:0]    branch_target,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_data,
   output logic [INSTR_WIDTH-1:0] instruction_out,
   output logic [PC_WIDTH-1:0]    pc_out,
   output logic                   valid_out,
   output logic                   halted,
   output logic [CNT_WIDTH-1:0]   dynamic_count,
   output logic [1:0]             dbg_state
);

   localparam logic [PC_WIDTH-1:0]  PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   fetch_state_t           r_state;
   logic [PC_WIDTH-1:0]    r_pc;
   logic [CNT_WIDTH-1:0]   r_cnt;
   logic                   r_halted;

   fetch_state_t           w_state_next;
   logic [PC_WIDTH-1:0]    w_pc_next;
   logic [CNT_WIDTH-1:0]   w_cnt_next;
   logic                   w_halted_next;
   logic                   w_load;
   logic                   w_flush;
   logic                   w_is_halt;
   logic [CNT_WIDTH-1:0]   w_cnt_inc;

   // Opcode field of the word currently on the ROM bus
   assign w_is_halt = (imem_data[INSTR_WIDTH-1 -: 5] == HALT_OP);

   // Counter increment that sticks at all-ones
   assign w_cnt_inc = (r_cnt == {CNT_WIDTH{1'b1}}) ? r_cnt : (r_cnt + CNT_ONE);

   // State, PC, counter and halt flag registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_pc     <= '0;
         r_cnt    <= '0;
         r_halted <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_pc     <= w_pc_next;
         r_cnt    <= w_cnt_next;
         r_halted <= w_halted_next;
      end
   end

   // Next-state, PC, counter and IF/ID control decode
   always_comb begin
      w_state_next  = r_state;
      w_pc_next     = r_pc;
      w_cnt_next    = r_cnt;
      w_halted_next = r_halted;
      w_load        = 1'b0;
      w_flush       = 1'b0;

      if (start) begin
         w_pc_next     = start_addr;
         w_flush       = 1'b1;
         w_cnt_next    = '0;
         w_halted_next = 1'b0;
         w_state_next  = RUN;
      end else begin
         case (r_state)
            IDLE: begin
               // Keep a bubble in IF/ID; stall and branch have no meaning yet
               w_flush = 1'b1;
            end
            RUN: begin
               if (branch_taken) begin
                  // Redirect wins over stall and discards the wrong-path word
                  w_pc_next = branch_target;
                  w_flush   = 1'b1;
               end else if (stall) begin
                  // Everything holds; a halt word on the bus is ignored here
               end else begin
                  w_load     = 1'b1;
                  w_cnt_next = w_cnt_inc;
                  if (w_is_halt) begin
                     w_state_next  = HALTED;
                     w_halted_next = 1'b1;
                  end else begin
                     w_pc_next = r_pc + PC_ONE;
                  end
               end
            end
            HALTED: begin
               if (branch_taken) begin
                  // The halt was on a mispredicted path: cancel it and resume
                  w_pc_next     = branch_target;
                  w_flush       = 1'b1;
                  w_halted_next = 1'b0;
                  w_state_next  = RUN;
               end else begin
                  // Halt word was visible for one cycle; bubbles from now on
                  w_flush = 1'b1;
               end
            end
            default: begin
               w_state_next = IDLE;
               w_flush      = 1'b1;
            end
         endcase
      end
   end

   if_id_reg #(
      .PC_WIDTH    (PC_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH),
      .BUBBLE      (BUBBLE)
   ) u_if_id (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load),
      .i_flush (w_flush),
      .i_instr (imem_data),
      .i_pc    (r_pc),
      .o_instr (instruction_out),
      .o_pc    (pc_out),
      .o_valid (valid_out)
   );

   assign imem_addr     = r_pc;
   assign halted        = r_halted;
   assign dynamic_count = r_cnt;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-cycle input/expected
// records, plus hand-written sequences for async reset, IDLE behaviour
// and counter saturation (on a second instance with a 3-bit counter).
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [8:0] BUB = 9'b110110000;

  // clock/reset block
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main DUT signals
  logic       start = 1'b0;
  logic [7:0] start_addr = '0;
  logic       stall = 1'b0;
  logic       branch_taken = 1'b0;
  logic [7:0] branch_target = '0;
  logic [7:0] imem_addr;
  logic [8:0] imem_data;
  logic [8:0] instruction_out;
  logic [7:0] pc_out;
  logic       valid_out;
  logic       halted;
  logic [15:0] dynamic_count;
  logic [1:0] dbg_state;

  logic [8:0] rom [0:255];
  assign imem_data = rom[imem_addr];

  fetch_unit u_dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .start_addr      (start_addr),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .valid_out       (valid_out),
    .halted          (halted),
    .dynamic_count   (dynamic_count),
    .dbg_state       (dbg_state)
  );

  // saturation instance: 3-bit counter, ROM always returns a plain word
  logic       s_start = 1'b0;
  logic [7:0] s_addr;
  logic [8:0] s_instr;
  logic [7:0] s_pc;
  logic       s_valid;
  logic       s_halted;
  logic [2:0] s_cnt;
  logic [1:0] s_state;

  fetch_unit #(.CNT_WIDTH(3)) u_sat (
    .clk             (clk),
    .reset           (reset),
    .start           (s_start),
    .start_addr      (8'h20),
    .stall           (1'b0),
    .branch_taken    (1'b0),
    .branch_target   (8'h00),
    .imem_addr       (s_addr),
    .imem_data       (9'h011),
    .instruction_out (s_instr),
    .pc_out          (s_pc),
    .valid_out       (s_valid),
    .halted          (s_halted),
    .dynamic_count   (s_cnt),
    .dbg_state       (s_state)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // vector record: inputs then expected post-edge outputs
  typedef struct {
    logic       st;
    logic [7:0] sa;
    logic       stl;
    logic       br;
    logic [7:0] tgt;
    logic [8:0] e_instr;
    logic [7:0] e_pc;
    logic       e_valid;
    logic       e_halt;
    logic [15:0] e_cnt;
    logic [7:0] e_addr;
    logic [1:0] e_st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic [7:0] sa, input logic stl, input logic br,
                     input logic [7:0] tgt, input logic [8:0] ei, input logic [7:0] ep,
                     input logic ev, input logic eh, input logic [15:0] ec,
                     input logic [7:0] ea, input logic [1:0] es);
    vec_t v;
    v.st = st; v.sa = sa; v.stl = stl; v.br = br; v.tgt = tgt;
    v.e_instr = ei; v.e_pc = ep; v.e_valid = ev; v.e_halt = eh;
    v.e_cnt = ec; v.e_addr = ea; v.e_st = es;
    vecs.push_back(v);
  endtask

  // driver: apply one vector on the falling edge, check after the rising edge
  task automatic apply(input int idx, input vec_t v);
    string tag;
    @(negedge clk);
    start = v.st; start_addr = v.sa; stall = v.stl;
    branch_taken = v.br; branch_target = v.tgt;
    @(posedge clk);
    #1;
    tag = $sformatf("v%0d", idx);
    check({tag, ".instr"}, 32'(instruction_out), 32'(v.e_instr));
    check({tag, ".valid"}, 32'(valid_out), 32'(v.e_valid));
    if (v.e_valid) check({tag, ".pc_out"}, 32'(pc_out), 32'(v.e_pc));
    check({tag, ".halted"}, 32'(halted), 32'(v.e_halt));
    check({tag, ".count"}, 32'(dynamic_count), 32'(v.e_cnt));
    check({tag, ".imem_addr"}, 32'(imem_addr), 32'(v.e_addr));
    check({tag, ".state"}, 32'(dbg_state), 32'(v.e_st));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".instr"}, 32'(instruction_out), 32'(BUB));
    check({tag, ".pc_out"}, 32'(pc_out), 32'h0);
    check({tag, ".valid"}, 32'(valid_out), 32'h0);
    check({tag, ".halted"}, 32'(halted), 32'h0);
    check({tag, ".count"}, 32'(dynamic_count), 32'h0);
    check({tag, ".imem_addr"}, 32'(imem_addr), 32'h0);
    check({tag, ".state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    // ROM: word i at address i (opcode never the halt pattern) with overrides
    for (int i = 0; i < 256; i++) rom[i] = 9'(i);
    rom[8'h10] = 9'h000;
    rom[8'h11] = 9'h021;
    rom[8'h12] = 9'h102;
    rom[8'h05] = 9'h1A0;

    //   st sa     stl br tgt    instr   pc     v  h  cnt addr   state
    add(1, 8'h10, 0, 0, 8'h00, BUB,    8'h00, 0, 0, 0, 8'h10, RUN);    // start
    add(0, 8'h00, 0, 0, 8'h00, 9'h000, 8'h10, 1, 0, 1, 8'h11, RUN);
    add(0, 8'h00, 0, 0, 8'h00, 9'h021, 8'h11, 1, 0, 2, 8'h12, RUN);
    add(0, 8'h00, 1, 0, 8'h00, 9'h021, 8'h11, 1, 0, 2, 8'h12, RUN);    // stall
    add(0, 8'h00, 1, 0, 8'h00, 9'h021, 8'h11, 1, 0, 2, 8'h12, RUN);    // stall
    add(0, 8'h00, 0, 0, 8'h00, 9'h102, 8'h12, 1, 0, 3, 8'h13, RUN);
    add(0, 8'h00, 1, 1, 8'h40, BUB,    8'h00, 0, 0, 3, 8'h40, RUN);    // branch under stall
    add(0, 8'h00, 0, 0, 8'h00, 9'h040, 8'h40, 1, 0, 4, 8'h41, RUN);
    add(1, 8'h03, 0, 0, 8'h00, BUB,    8'h00, 0, 0, 0, 8'h03, RUN);    // restart
    add(0, 8'h00, 0, 0, 8'h00, 9'h003, 8'h03, 1, 0, 1, 8'h04, RUN);
    add(0, 8'h00, 0, 0, 8'h00, 9'h004, 8'h04, 1, 0, 2, 8'h05, RUN);
    add(0, 8'h00, 1, 0, 8'h00, 9'h004, 8'h04, 1, 0, 2, 8'h05, RUN);    // halt on bus, stalled
    add(0, 8'h00, 0, 0, 8'h00, 9'h1A0, 8'h05, 1, 1, 3, 8'h05, HALTED); // halt latched
    add(0, 8'h00, 0, 0, 8'h00, BUB,    8'h00, 0, 1, 3, 8'h05, HALTED);
    add(0, 8'h00, 1, 0, 8'h00, BUB,    8'h00, 0, 1, 3, 8'h05, HALTED);
    add(0, 8'h00, 0, 1, 8'h08, BUB,    8'h00, 0, 0, 3, 8'h08, RUN);    // cancel halt
    add(0, 8'h00, 0, 0, 8'h00, 9'h008, 8'h08, 1, 0, 4, 8'h09, RUN);
    add(1, 8'hFF, 0, 0, 8'h00, BUB,    8'h00, 0, 0, 0, 8'hFF, RUN);    // wrap test
    add(0, 8'h00, 0, 0, 8'h00, 9'h0FF, 8'hFF, 1, 0, 1, 8'h00, RUN);
    add(0, 8'h00, 0, 0, 8'h00, 9'h000, 8'h00, 1, 0, 2, 8'h01, RUN);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) apply(i, vecs[i]);

    // async reset mid-run during a stall: no clock edge between assert and check
    @(negedge clk);
    start = 1'b0; stall = 1'b1; branch_taken = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_values("rst_run");
    @(negedge clk);
    reset = 1'b0;

    // IDLE ignores branch and stall
    branch_taken = 1'b1; branch_target = 8'h30; stall = 1'b1;
    @(posedge clk);
    #1;
    check("idle.imem_addr", 32'(imem_addr), 32'h0);
    check("idle.valid", 32'(valid_out), 32'h0);
    check("idle.state", 32'(dbg_state), 32'(IDLE));

    // async reset while HALTED
    @(negedge clk);
    branch_taken = 1'b0; stall = 1'b0; start = 1'b1; start_addr = 8'h05;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("hlt.halted", 32'(halted), 32'h1);
    check("hlt.instr", 32'(instruction_out), 32'h1A0);
    check("hlt.count", 32'(dynamic_count), 32'h1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_reset_values("rst_halt");
    @(negedge clk);
    reset = 1'b0;

    // counter saturation on the 3-bit instance
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("sat.count6", 32'(s_cnt), 32'h6);
    @(posedge clk);
    #1 check("sat.count7", 32'(s_cnt), 32'h7);
    repeat (3) @(posedge clk);
    #1 check("sat.hold", 32'(s_cnt), 32'h7);
    check("sat.valid", 32'(s_valid), 32'h1);
    check("sat.addr", 32'(s_addr), 32'h2A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
